// File: rtl/wave_monitor_pkg.sv
// Shared types and constants for the waveform period / high-time monitor.
package wave_monitor_pkg;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    // Saturation value of a width-bit counter (all ones).
    function automatic logic [31:0] cnt_sat(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/wm_sync_edge.sv
// Synchronizer chain for an asynchronous input, plus history flop and edge detection.
module wm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // NOTE: non-blocking assignments so each stage samples its neighbour's previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~hist_q;
    assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/wave_monitor.sv
// Measures period and high time of an asynchronous waveform, with a held result
// handed to a consumer through a valid/ready pair.
module wave_monitor
    import wave_monitor_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             timeout,
    output logic             overrun,
    output logic             led
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_W'(1);

    logic level, rise, fall;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] htime_q, htime_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             rise_q, fall_q, led_q;
    logic             meas_fire;

    wm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig_i   (sig_in),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // NOTE: every signal gets a default first, so no path through the block infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        timeout_d = 1'b0;
        meas_fire = 1'b0;
        if (!enable) begin
            state_d = ST_ARM;
            cnt_d   = '0;
        end else if (rise) begin
            // Every rise restarts the count; only a rise that closes a LOW phase measures.
            cnt_d     = CNT_W'(1);
            state_d   = ST_HIGH;
            meas_fire = (state_q == ST_LOW);
        end else begin
            case (state_q)
                ST_ARM: cnt_d = '0;
                ST_HIGH, ST_LOW: begin
                    if (cnt_q == CNT_PRE) begin
                        timeout_d = 1'b1;
                        state_d   = ST_ARM;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (state_q == ST_HIGH && fall) begin
                            hcnt_d  = cnt_q;
                            state_d = ST_LOW;
                        end
                    end
                end
                default: state_d = ST_ARM;
            endcase
        end
    end

    always_comb begin
        valid_d   = valid_q;
        period_d  = period_q;
        htime_d   = htime_q;
        overrun_d = overrun_q;
        if (meas_fire) begin
            if (!valid_q || meas_ready) begin
                period_d = cnt_q;
                htime_d  = hcnt_q;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && meas_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ARM;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            htime_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            led_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            htime_q   <= htime_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            rise_q    <= enable & rise;
            fall_q    <= enable & fall;
            led_q     <= ~level;
        end
    end

    assign meas_valid = valid_q;
    assign period     = period_q;
    assign high_time  = htime_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign timeout    = timeout_q;
    assign overrun    = overrun_q;
    assign led        = led_q;

endmodule

// File: tb/tb_wave_monitor.sv
// Scoreboard bench for wave_monitor: stimulus pushes expected results, a negedge
// monitor pops and compares on every valid/ready handshake.
module tb_wave_monitor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sig_in = 1'b0;
    logic         enable = 1'b0;
    logic         meas_ready = 1'b0;
    logic         meas_valid;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         rise_pulse;
    logic         fall_pulse;
    logic         timeout;
    logic         overrun;
    logic         led;

    typedef struct packed {
        logic [W-1:0] period;
        logic [W-1:0] high;
    } meas_t;

    meas_t exp_q[$];
    meas_t got_e;
    int    n_cmp = 0;
    int    n_err = 0;
    int    first_to;
    int    n_to;
    bit    saw_valid;

    always #5 clk = ~clk;

    wave_monitor #(.CNT_W(W), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .enable     (enable),
        .meas_ready (meas_ready),
        .meas_valid (meas_valid),
        .period     (period),
        .high_time  (high_time),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .timeout    (timeout),
        .overrun    (overrun),
        .led        (led)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_meas(input logic [W-1:0] p, input logic [W-1:0] h);
        meas_t m;
        m.period = p;
        m.high   = h;
        exp_q.push_back(m);
    endtask

    // Monitor: one transfer per cycle with valid and ready both high.
    always @(negedge clk) begin
        if (rst_n && meas_valid && meas_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_meas: got period %0d high %0d, expected no result", period, high_time);
            end else begin
                got_e = exp_q.pop_front();
                check("meas_period", 32'(period), 32'(got_e.period));
                check("meas_high", 32'(high_time), 32'(got_e.high));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        step(2);
        check("rst_led", 32'(led), 32'd1);
        check("rst_valid", 32'(meas_valid), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_high", 32'(high_time), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        enable = 1'b1;
        meas_ready = 1'b1;
        step(3);

        // Single toggle: rise strobe three edges later, led follows the last stage
        sig_in = 1'b1;
        step(1); check("rise_lat1", 32'(rise_pulse), 32'd0); check("led_lat1", 32'(led), 32'd1);
        step(1); check("rise_lat2", 32'(rise_pulse), 32'd0); check("led_lat2", 32'(led), 32'd1);
        step(1); check("rise_lat3", 32'(rise_pulse), 32'd1); check("led_lat3", 32'(led), 32'd0);
        step(1); check("rise_width", 32'(rise_pulse), 32'd0);
        sig_in = 1'b0;
        step(2); check("fall_lat2", 32'(fall_pulse), 32'd0);
        step(1); check("fall_lat3", 32'(fall_pulse), 32'd1);
        step(1); check("fall_width", 32'(fall_pulse), 32'd0);
        step(2);

        // Square wave, period 10, high 4: each later rise measures
        for (int i = 0; i < 3; i++) begin
            expect_meas(8'd10, 8'd4);
            sig_in = 1'b1; step(4);
            sig_in = 1'b0; step(6);
        end

        // Rise A measures 10/4 and is held; rise B (period 8, high 3) arrives with ready high
        meas_ready = 1'b0;
        expect_meas(8'd10, 8'd4);
        sig_in = 1'b1; step(3);
        sig_in = 1'b0; step(5);
        expect_meas(8'd8, 8'd3);
        sig_in = 1'b1; step(2);
        meas_ready = 1'b1; step(1);
        meas_ready = 1'b0;
        check("same_cycle_valid", 32'(meas_valid), 32'd1);
        check("same_cycle_period", 32'(period), 32'd8);
        check("same_cycle_high", 32'(high_time), 32'd3);
        check("same_cycle_overrun", 32'(overrun), 32'd0);
        sig_in = 1'b0;
        meas_ready = 1'b1; step(1);
        meas_ready = 1'b0;
        check("drain_valid", 32'(meas_valid), 32'd0);
        step(8);

        // Rise C gives 12/3 (held), rise D gives 20/5 (dropped)
        expect_meas(8'd12, 8'd3);
        sig_in = 1'b1; step(5);
        sig_in = 1'b0; step(15);
        sig_in = 1'b1; step(4);
        check("ovr_period_held", 32'(period), 32'd12);
        check("ovr_high_held", 32'(high_time), 32'd3);
        check("ovr_valid", 32'(meas_valid), 32'd1);
        check("ovr_sticky", 32'(overrun), 32'd1);
        meas_ready = 1'b1; step(1);
        check("ovr_ready_clears", 32'(meas_valid), 32'd0);
        check("ovr_still_set", 32'(overrun), 32'd1);

        // Reset mid-measurement, in LOW
        sig_in = 1'b0; step(6);
        rst_n = 1'b0;
        #1;
        check("mid_rst_led", 32'(led), 32'd1);
        check("mid_rst_valid", 32'(meas_valid), 32'd0);
        check("mid_rst_period", 32'(period), 32'd0);
        check("mid_rst_high", 32'(high_time), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_pulses", 32'({rise_pulse, fall_pulse, timeout}), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(2);
        sig_in = 1'b1; step(4);
        sig_in = 1'b0; step(6);
        expect_meas(8'd10, 8'd4);
        sig_in = 1'b1; step(4);
        sig_in = 1'b0; step(6);

        // Disabled: strobes suppressed, led keeps following
        enable = 1'b0;
        sig_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("dis_rise", 32'(rise_pulse), 32'd0);
        end
        check("dis_led", 32'(led), 32'd0);
        sig_in = 1'b0;
        step(4);
        check("dis_fall", 32'(fall_pulse), 32'd0);
        check("dis_led_back", 32'(led), 32'd1);
        enable = 1'b1;
        step(2);

        // Saturation: held high after the arming rise
        first_to = -1;
        n_to = 0;
        saw_valid = 1'b0;
        sig_in = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            step(1);
            if (timeout) begin
                n_to++;
                if (first_to < 0) first_to = i;
            end
            if (meas_valid) saw_valid = 1'b1;
        end
        check("timeout_cycle", 32'(first_to), 32'd257);
        check("timeout_count", 32'(n_to), 32'd1);
        check("timeout_no_valid", 32'(saw_valid), 32'd0);

        // After timeout the first rise only arms
        sig_in = 1'b0; step(6);
        sig_in = 1'b1; step(4);
        sig_in = 1'b0; step(6);
        expect_meas(8'd10, 8'd4);
        sig_in = 1'b1; step(4);
        sig_in = 1'b0; step(6);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_overrun", 32'(overrun), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
